// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port: picks one of three
// producers per cycle, steers the external 3:1 mux and registers its output as a write.
module wb_port_arbiter #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       req_valid,
   input  logic [AW-1:0]    req_addr0,
   input  logic [AW-1:0]    req_addr1,
   input  logic [AW-1:0]    req_addr2,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   input  logic [WIDTH-1:0] req_data2,
   output logic [2:0]       req_ready,
   output logic [1:0]       mux_sel,
   input  logic [WIDTH-1:0] mux_out,
   input  logic             wr_stall,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic [WIDTH-1:0] wr_data,
   output logic [15:0]      grant_cnt
);

   logic [1:0]       last_grant_r;
   logic             wr_en_r;
   logic [AW-1:0]    wr_addr_r;
   logic [WIDTH-1:0] wr_data_r;
   logic [15:0]      grant_cnt_r;

   logic [1:0]       cand0_s, cand1_s, cand2_s;
   logic [1:0]       winner_s;
   logic             xfer_s;
   logic [AW-1:0]    win_addr_s;
   logic [2:0]       req_ready_s;
   logic [1:0]       mux_sel_s;
   logic             unused_data_s;

   // Request data reaches the write port only through the external mux.
   assign unused_data_s = ^{req_data0, req_data1, req_data2};

   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         2'd0:    nxt = 2'd1;
         2'd1:    nxt = 2'd2;
         default: nxt = 2'd0;
      endcase
      return nxt;
   endfunction

   assign cand0_s = next_idx(last_grant_r);
   assign cand1_s = next_idx(cand0_s);
   assign cand2_s = next_idx(cand1_s);

   // Round-robin winner search starting after the last granted requester
   always_comb begin
      winner_s = 2'd0;
      xfer_s   = 1'b0;
      if (!rst_n || wr_stall) begin
         winner_s = 2'd0;
         xfer_s   = 1'b0;
      end else if (req_valid[cand0_s]) begin
         winner_s = cand0_s;
         xfer_s   = 1'b1;
      end else if (req_valid[cand1_s]) begin
         winner_s = cand1_s;
         xfer_s   = 1'b1;
      end else if (req_valid[cand2_s]) begin
         winner_s = cand2_s;
         xfer_s   = 1'b1;
      end else begin
         winner_s = 2'd0;
         xfer_s   = 1'b0;
      end
   end

   // One-hot ready, mux select and destination address of the winner
   always_comb begin
      req_ready_s = 3'b000;
      mux_sel_s   = 2'b00;
      win_addr_s  = req_addr0;
      case (winner_s)
         2'd0:    win_addr_s = req_addr0;
         2'd1:    win_addr_s = req_addr1;
         2'd2:    win_addr_s = req_addr2;
         default: win_addr_s = req_addr0;
      endcase
      if (xfer_s) begin
         mux_sel_s = winner_s;
         case (winner_s)
            2'd0:    req_ready_s = 3'b001;
            2'd1:    req_ready_s = 3'b010;
            2'd2:    req_ready_s = 3'b100;
            default: req_ready_s = 3'b000;
         endcase
      end else begin
         req_ready_s = 3'b000;
         mux_sel_s   = 2'b00;
      end
   end

   // Arbitration state and registered write port; r0 writes are counted but not strobed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= 2'd2;
         wr_en_r      <= 1'b0;
         wr_addr_r    <= {AW{1'b0}};
         wr_data_r    <= {WIDTH{1'b0}};
         grant_cnt_r  <= 16'd0;
      end else if (xfer_s) begin
         last_grant_r <= winner_s;
         wr_en_r      <= (win_addr_s != {AW{1'b0}});
         wr_addr_r    <= win_addr_s;
         wr_data_r    <= mux_out;
         grant_cnt_r  <= grant_cnt_r + 16'd1;
      end else begin
         wr_en_r      <= 1'b0;
      end
   end

   assign req_ready = req_ready_s;
   assign mux_sel   = mux_sel_s;
   assign wr_en     = wr_en_r;
   assign wr_addr   = wr_addr_r;
   assign wr_data   = wr_data_r;
   assign grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter; the 3:1 write-back mux is modelled here
// so mux_out follows mux_sel as it would in the datapath.
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [4:0]  req_addr0, req_addr1, req_addr2;
   logic [31:0] req_data0, req_data1, req_data2;
   logic [2:0]  req_ready;
   logic [1:0]  mux_sel;
   logic [31:0] mux_out;
   logic        wr_stall;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [15:0] grant_cnt;

   int checks;
   int failures;

   wb_port_arbiter #(.WIDTH(32), .AW(5)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
      .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
      .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
      .req_ready(req_ready), .mux_sel(mux_sel), .mux_out(mux_out),
      .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .grant_cnt(grant_cnt)
   );

   assign mux_out = (mux_sel == 2'd0) ? req_data0 :
                    (mux_sel == 2'd1) ? req_data1 :
                    (mux_sel == 2'd2) ? req_data2 : 32'hBAD0BAD0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      wr_stall  = 1'b0;
      req_valid = 3'b111;
      req_addr0 = 5'd1;  req_addr1 = 5'd2;  req_addr2 = 5'd3;
      req_data0 = 32'd0; req_data1 = 32'd1; req_data2 = 32'd2;

      // reset held with all requesters valid
      tick(); tick();
      chk("rst_ready",   32'(req_ready), 32'h0);
      chk("rst_mux_sel", 32'(mux_sel),   32'h0);
      chk("rst_wr_en",   32'(wr_en),     32'h0);
      chk("rst_wr_addr", 32'(wr_addr),   32'h0);
      chk("rst_wr_data", wr_data,        32'h0);
      chk("rst_cnt",     32'(grant_cnt), 32'h0);

      // release, then six cycles of all-valid round robin
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk("rr_ready",   32'(req_ready), 32'(3'b001 << (i % 3)));
         chk("rr_mux_sel", 32'(mux_sel),   32'(i % 3));
         tick();
         chk("rr_wr_en",   32'(wr_en),     32'h1);
         chk("rr_wr_addr", 32'(wr_addr),   32'((i % 3) + 1));
         chk("rr_wr_data", wr_data,        32'(i % 3));
      end
      chk("rr_cnt", 32'(grant_cnt), 32'd6);

      // grant to 0, then stall for two cycles
      chk("pre_stall_ready", 32'(req_ready), 32'h1);
      tick();
      chk("pre_stall_wr_en", 32'(wr_en), 32'h1);
      wr_stall = 1'b1;
      #1;
      chk("stall1_ready",   32'(req_ready), 32'h0);
      chk("stall1_mux_sel", 32'(mux_sel),   32'h0);
      tick();
      chk("stall1_wr_en",   32'(wr_en),     32'h0);
      chk("stall1_wr_addr", 32'(wr_addr),   32'd1);
      chk("stall2_ready",   32'(req_ready), 32'h0);
      tick();
      chk("stall2_wr_en",   32'(wr_en),     32'h0);
      chk("stall_cnt",      32'(grant_cnt), 32'd7);
      wr_stall = 1'b0;
      #1;
      chk("unstall_ready",   32'(req_ready), 32'h2);
      chk("unstall_mux_sel", 32'(mux_sel),   32'h1);
      tick();
      chk("unstall_wr_en",   32'(wr_en),     32'h1);
      chk("unstall_wr_addr", 32'(wr_addr),   32'd2);
      chk("unstall_wr_data", wr_data,        32'd1);
      chk("unstall_cnt",     32'(grant_cnt), 32'd8);

      // write to r0: accepted and counted, no strobe
      req_valid = 3'b100;
      req_addr2 = 5'd0;
      req_data2 = 32'hDEADBEEF;
      #1;
      chk("r0_ready",   32'(req_ready), 32'h4);
      chk("r0_mux_sel", 32'(mux_sel),   32'h2);
      tick();
      chk("r0_wr_en",   32'(wr_en),     32'h0);
      chk("r0_cnt",     32'(grant_cnt), 32'd9);

      // single requester 1
      req_valid = 3'b010;
      req_addr1 = 5'd7;
      req_data1 = 32'h1;
      #1;
      chk("single_ready",   32'(req_ready), 32'h2);
      chk("single_mux_sel", 32'(mux_sel),   32'h1);
      tick();
      chk("single_wr_en",   32'(wr_en),     32'h1);
      chk("single_wr_addr", 32'(wr_addr),   32'd7);
      chk("single_wr_data", wr_data,        32'h1);

      // withdrawn request has no effect
      req_valid = 3'b000;
      #1;
      chk("idle_ready", 32'(req_ready), 32'h0);
      tick();
      chk("idle_wr_en", 32'(wr_en),     32'h0);
      chk("idle_cnt",   32'(grant_cnt), 32'd10);

      // async reset while wr_en is high
      req_valid = 3'b111;
      req_addr2 = 5'd5;
      req_data2 = 32'h2;
      #1;
      chk("pre_arst_ready", 32'(req_ready), 32'h4);
      tick();
      chk("pre_arst_wr_en", 32'(wr_en), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_wr_en",   32'(wr_en),     32'h0);
      chk("arst_wr_addr", 32'(wr_addr),   32'h0);
      chk("arst_cnt",     32'(grant_cnt), 32'h0);
      chk("arst_ready",   32'(req_ready), 32'h0);
      #2;
      rst_n = 1'b1;
      #1;
      chk("post_arst_ready",   32'(req_ready), 32'h1);
      chk("post_arst_mux_sel", 32'(mux_sel),   32'h0);
      tick();
      chk("post_arst_wr_en",   32'(wr_en),     32'h1);
      chk("post_arst_wr_addr", 32'(wr_addr),   32'd1);
      chk("post_arst_cnt",     32'(grant_cnt), 32'd1);

      // counter wrap at 2^16 with continuous transfers
      repeat (65534) @(posedge clk);
      #1;
      chk("cnt_max",  32'(grant_cnt), 32'h0000FFFF);
      tick();
      chk("cnt_wrap", 32'(grant_cnt), 32'h0);
      chk("cnt_wrap_wr_en", 32'(wr_en), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
